// File: rtl/mul_repeated_add_pkg.sv
// Shared types and defaults for the repeated-addition multiplier.
package mul_repeated_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_B = 2'd1,
      ST_ADD    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mul_datapath.sv
// Multiplier datapath: operand capture, min/max split, 2*WIDTH accumulator and down-counter.
// One action per cycle (load A, load B, or add); no flow control of its own.
module mul_datapath
   import mul_repeated_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               load_a,
   input  logic               load_b,
   input  logic               add_en,
   input  logic [WIDTH-1:0]   data,
   output logic [2*WIDTH-1:0] product,
   output logic               count_zero
);

   logic [WIDTH-1:0]   opa_q,     opa_d;
   logic [WIDTH-1:0]   addend_q,  addend_d;
   logic [WIDTH-1:0]   count_q,   count_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   always_comb begin
      opa_d     = opa_q;
      addend_d  = addend_q;
      count_d   = count_q;
      product_d = product_q;
      if (load_a) begin
         opa_d     = data;
         product_d = '0;
      end else if (load_b) begin
         // Iterate over the smaller operand; a tie keeps opA as the addend.
         if (opa_q >= data) begin
            addend_d = opa_q;
            count_d  = data;
         end else begin
            addend_d = data;
            count_d  = opa_q;
         end
      end else if (add_en) begin
         product_d = product_q + {{WIDTH{1'b0}}, addend_q};
         count_d   = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         opa_q     <= '0;
         addend_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         opa_q     <= opa_d;
         addend_q  <= addend_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign product    = product_q;
   assign count_zero = (count_q == '0);

endmodule

// File: rtl/mul_repeated_add.sv
// Unsigned multiplier by repeated addition; done pulses min(A,B)+2 edges after start.
// No backpressure: start is only accepted in IDLE and is dropped otherwise.
module mul_repeated_add
   import mul_repeated_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               start,
   input  logic [WIDTH-1:0]   data,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   state_t state_q, state_d;
   logic   busy_q,  busy_d;
   logic   done_q,  done_d;
   logic   load_a;
   logic   load_b;
   logic   add_en;
   logic   count_zero;

   assign load_a = (state_q == ST_IDLE) && start;
   assign load_b = (state_q == ST_LOAD_B);
   assign add_en = (state_q == ST_ADD) && !count_zero;

   // busy/done are the registered image of the next state.
   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD_B;
               busy_d  = 1'b1;
            end
         end
         ST_LOAD_B: begin
            state_d = ST_ADD;
            busy_d  = 1'b1;
         end
         ST_ADD: begin
            if (count_zero) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   mul_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk        (clk),
      .clear      (clear),
      .load_a     (load_a),
      .load_b     (load_b),
      .add_en     (add_en),
      .data       (data),
      .product    (product),
      .count_zero (count_zero)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_mul_repeated_add.sv
// Directed, table-driven bench for mul_repeated_add (WIDTH=8).
module tb_mul_repeated_add;
   import mul_repeated_add_pkg::*;

   logic        clk;
   logic        clear;
   logic        start;
   logic [7:0]  data;
   logic [15:0] product;
   logic        busy;
   logic        done;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         prod;
      int         lat;
   } vec_t;

   vec_t vecs [8];

   mul_repeated_add #(.WIDTH(8)) dut (
      .clk     (clk),
      .clear   (clear),
      .start   (start),
      .data    (data),
      .product (product),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called #1 after an edge; leaves the bench #1 after the edge following done.
   task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                          input int exp_prod, input int exp_lat, input int stray_at);
      int lat;
      int busy_cnt;
      start = 1'b1;
      data  = a;
      @(posedge clk); #1;
      busy_cnt = busy ? 1 : 0;
      start = 1'b0;
      data  = b;
      @(posedge clk); #1;
      lat  = 1;
      data = 8'hA5;
      while (!done && lat < 400) begin
         busy_cnt += busy ? 1 : 0;
         start = (lat == stray_at);
         if (start) data = 8'd9;
         @(posedge clk); #1;
         start = 1'b0;
         data  = 8'hA5;
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: no done after %0d edges, expected %0d", name, lat, exp_lat);
      end else begin
         check({name, "_latency"}, lat, exp_lat);
         check({name, "_product"}, product, exp_prod);
         check({name, "_busy_at_done"}, busy, 0);
         check({name, "_busy_cycles"}, busy_cnt, exp_lat);
      end
      @(posedge clk); #1;
      check({name, "_done_pulse"}, done, 0);
      check({name, "_product_hold"}, product, exp_prod);
   endtask

   initial begin
      vecs[0] = '{a: 8'd6,   b: 8'd7,   prod: 42,    lat: 8};
      vecs[1] = '{a: 8'd200, b: 8'd3,   prod: 600,   lat: 5};
      vecs[2] = '{a: 8'd3,   b: 8'd200, prod: 600,   lat: 5};
      vecs[3] = '{a: 8'd0,   b: 8'd255, prod: 0,     lat: 2};
      vecs[4] = '{a: 8'd255, b: 8'd0,   prod: 0,     lat: 2};
      vecs[5] = '{a: 8'd255, b: 8'd255, prod: 65025, lat: 257};
      vecs[6] = '{a: 8'd1,   b: 8'd1,   prod: 1,     lat: 3};
      vecs[7] = '{a: 8'd12,  b: 8'd12,  prod: 144,   lat: 14};

      clear = 1'b1;
      start = 1'b0;
      data  = 8'd0;
      @(posedge clk);
      @(posedge clk); #1;
      check("reset_product", product, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      clear = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, -1);
      end

      // Stray start with data=9 in the middle of ADD must be dropped.
      run_mul("restart_ignored", 8'd10, 8'd12, 120, 12, 4);

      // Clear during the 5th ADD cycle of 50x50: after edge 5 four adds are in.
      start = 1'b1;
      data  = 8'd50;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
      end
      check("midop_partial_product", product, 200);
      check("midop_busy", busy, 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("midop_clr_product", product, 0);
      check("midop_clr_busy", busy, 0);
      check("midop_clr_done", done, 0);
      check("midop_clr_state", dut.state_q, ST_IDLE);
      @(posedge clk); #1;
      check("midop_stays_idle", busy, 0);
      run_mul("after_clear", 8'd4, 8'd5, 20, 6, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
